// File: rtl/goldschmidt_div_seq_pkg.sv
// Shared types and constants for the Goldschmidt significand divider.
// The seed table function is used only when GS_SEED_LUT_EN is defined.
package goldschmidt_div_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCALE_N,
    S_SCALE_D,
    S_ITER_N,
    S_ITER_D,
    S_DONE
  } gs_state_t;

  // Initial scale factor 0.75 in the internal Q2.(iw-2) format.
  function automatic logic [63:0] k0_const(input int unsigned iw);
    return 64'd3 << (iw - 4);
  endfunction

  // Reciprocal of the midpoint of seed interval idx, rounded to lut_bits+2
  // fraction bits and then aligned to Q2.(iw-2).
  // midpoint = 1 + (2*idx+1)/2^(lut_bits+1), so 1/midpoint = 2^(L+1)/(2^(L+1)+2*idx+1).
  function automatic logic [63:0] seed_lut(input int unsigned idx,
                                           input int unsigned lut_bits,
                                           input int unsigned iw);
    longint unsigned num;
    longint unsigned den;
    longint unsigned k;
    num = 64'd1 << (2 * lut_bits + 3);
    den = (64'd1 << (lut_bits + 1)) + 64'(2 * idx + 1);
    k   = (2 * num + den) / (2 * den);
    return 64'(k) << (iw - 2 - (lut_bits + 2));
  endfunction

endpackage

// File: rtl/goldschmidt_div_seq_if.sv
// Start/done request bundle between the FP divide controller and the
// significand divider. The controller is the master, the divider the slave.
interface goldschmidt_div_seq_if #(
  parameter int unsigned WIDTH = 24
);
  logic             start;
  logic [WIDTH-1:0] numerator;
  logic [WIDTH-1:0] denominator;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic             dz;

  modport master (
    output start, numerator, denominator,
    input  busy, done, quotient, dz
  );

  modport slave (
    input  start, numerator, denominator,
    output busy, done, quotient, dz
  );
endinterface

// File: rtl/goldschmidt_div_seq_datapath.sv
// Goldschmidt datapath: N/D/K registers, one shared multiplier used for N on
// one cycle and D on the next, and the 2-D correction term.
// GS_SEED_LUT_EN selects a denominator-indexed seed table for K0 (and adds
// the LUT_BITS parameter); otherwise K0 is the constant 0.75.
module goldschmidt_div_seq_datapath
  import goldschmidt_div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned GUARD = 4
`ifdef GS_SEED_LUT_EN
  ,
  parameter int unsigned LUT_BITS = 4
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step_n,
  input  logic             i_step_d,
  input  logic [WIDTH-1:0] i_num,
  input  logic [WIDTH-1:0] i_den,
  output logic [WIDTH-1:0] o_quo
);

  localparam int unsigned   IW  = WIDTH + GUARD + 1;
  localparam logic [IW-1:0] TWO = {1'b1, {(IW-1){1'b0}}};

  logic [IW-1:0]   r_n;
  logic [IW-1:0]   r_d;
  logic [IW-1:0]   r_k;
  logic [IW-1:0]   w_k0;
  logic [IW-1:0]   w_mul_a;
  logic [IW-1:0]   w_mul_q;
  logic [IW-1:0]   w_two_minus;
  logic [2*IW-1:0] w_prod;

  // Q1.(WIDTH-1) operand into Q2.(IW-2): one zero integer bit above, GUARD zeros below.
  function automatic logic [IW-1:0] ext_op(input logic [WIDTH-1:0] x);
    return {1'b0, x, {GUARD{1'b0}}};
  endfunction

  // Drop the guard bits; anything at or above 2.0 saturates to all-ones.
  function automatic logic [WIDTH-1:0] sat_quo(input logic [IW-1:0] n);
    if (n[IW-1]) return '1;
    return WIDTH'(n[IW-2:0] >> GUARD);
  endfunction

`ifdef GS_SEED_LUT_EN
  logic [IW-1:0] w_lut [2**LUT_BITS];
  for (genvar gi = 0; gi < 2**LUT_BITS; gi++) begin : g_lut
    localparam logic [63:0] ENTRY = seed_lut(gi, LUT_BITS, IW);
    assign w_lut[gi] = ENTRY[IW-1:0];
  end
  // The leading 1 of a valid divisor is implied; index with the bits below it.
  assign w_k0 = w_lut[i_den[WIDTH-2 -: LUT_BITS]];
`else
  localparam logic [63:0] K0_WIDE = k0_const(IW);
  assign w_k0 = K0_WIDE[IW-1:0];
`endif

  // Shared multiplier: the D step uses D, every other step uses N; K is the common factor.
  assign w_mul_a     = i_step_d ? r_d : r_n;
  assign w_prod      = {{IW{1'b0}}, w_mul_a} * {{IW{1'b0}}, r_k};
  // Q4 product realigned to Q2 by truncation; the two top integer bits are dropped.
  assign w_mul_q     = IW'(w_prod >> (IW - 2));
  assign w_two_minus = TWO - w_mul_q;

  // Load operands and seed on accept, then refine N and D/K on alternate cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n <= '0;
      r_d <= '0;
      r_k <= '0;
    end else if (i_load) begin
      r_n <= ext_op(i_num);
      r_d <= ext_op(i_den);
      r_k <= w_k0;
    end else if (i_step_n) begin
      r_n <= w_mul_q;
    end else if (i_step_d) begin
      r_d <= w_mul_q;
      r_k <= w_two_minus;
    end
  end

  assign o_quo = sat_quo(r_n);

endmodule

// File: rtl/goldschmidt_div_seq.sv
// Iterative Goldschmidt divider for normalised significands with start/done
// handshake. One accepted request runs SCALE_N, SCALE_D, ITERS x (ITER_N,
// ITER_D) and DONE; a divisor without its leading 1 skips straight to DONE
// and reports dz. Optional seed table: define GS_SEED_LUT_EN (adds LUT_BITS).
module goldschmidt_div_seq
  import goldschmidt_div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned GUARD = 4,
  parameter int unsigned ITERS = 5
`ifdef GS_SEED_LUT_EN
  ,
  parameter int unsigned LUT_BITS = 4
`endif
) (
  input logic                  clk,
  input logic                  reset,
  goldschmidt_div_seq_if.slave bus
);

  localparam int unsigned      CNT_W     = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

  gs_state_t        r_state;
  logic [CNT_W-1:0] r_iter;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;
  logic             r_dz_pend;
  logic [WIDTH-1:0] r_quotient;

  logic             w_accept;
  logic             w_den_ok;
  logic             w_step_n;
  logic             w_step_d;
  logic [WIDTH-1:0] w_q;

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_den_ok = bus.denominator[WIDTH-1];
  assign w_step_n = (r_state == S_SCALE_N) || (r_state == S_ITER_N);
  assign w_step_d = (r_state == S_SCALE_D) || (r_state == S_ITER_D);

  goldschmidt_div_seq_datapath #(
    .WIDTH    (WIDTH),
    .GUARD    (GUARD)
`ifdef GS_SEED_LUT_EN
    ,
    .LUT_BITS (LUT_BITS)
`endif
  ) u_dp (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_accept),
    .i_step_n (w_step_n),
    .i_step_d (w_step_d),
    .i_num    (bus.numerator),
    .i_den    (bus.denominator),
    .o_quo    (w_q)
  );

  // Sequencer with registered busy/done/quotient/dz; requests are taken only in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_iter     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dz       <= 1'b0;
      r_dz_pend  <= 1'b0;
      r_quotient <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          // busy drops here after the done cycle unless a new request arrives
          r_busy <= bus.start;
          if (bus.start) begin
            r_iter    <= '0;
            r_dz_pend <= ~w_den_ok;
            r_state   <= w_den_ok ? S_SCALE_N : S_DONE;
          end
        end
        S_SCALE_N: r_state <= S_SCALE_D;
        S_SCALE_D: r_state <= S_ITER_N;
        S_ITER_N:  r_state <= S_ITER_D;
        S_ITER_D: begin
          if (r_iter == LAST_ITER) begin
            r_state <= S_DONE;
          end else begin
            r_iter  <= r_iter + 1'b1;
            r_state <= S_ITER_N;
          end
        end
        S_DONE: begin
          r_done     <= 1'b1;
          r_dz       <= r_dz_pend;
          r_quotient <= r_dz_pend ? '1 : w_q;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.quotient = r_quotient;
  assign bus.dz       = r_dz;

endmodule

// File: tb/tb_goldschmidt_div_seq.sv
// Directed bench for goldschmidt_div_seq at WIDTH=16, GUARD=4, ITERS=4.
// Expected quotients are hand-computed N/D in Q1.15, truncated.
module tb_goldschmidt_div_seq;

  localparam int unsigned W = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  goldschmidt_div_seq_if #(.WIDTH(W)) bus ();

  goldschmidt_div_seq #(
    .WIDTH (W),
    .GUARD (4),
    .ITERS (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint obs, input longint exp, input longint tol);
    longint diff;
    n_cmp++;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // Issue one request and follow it to its done pulse. inj_cyc > 0 pulses a
  // second, different request so that it is sampled at accept edge + inj_cyc.
  task automatic run_op(input string name, input logic [15:0] n, input logic [15:0] d,
                        input logic [15:0] exp_q, input int tol, input int exp_lat,
                        input logic exp_z, input int inj_cyc);
    int          lat;
    logic [15:0] q;
    logic        z;
    logic        busy_done;
    logic        busy_inj;
    lat       = -1;
    q         = '0;
    z         = 1'b0;
    busy_done = 1'b0;
    busy_inj  = 1'b0;
    @(posedge clk); #1;
    bus.start       = 1'b1;
    bus.numerator   = n;
    bus.denominator = d;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (c == inj_cyc) busy_inj = bus.busy;
      if (c + 1 == inj_cyc) begin
        bus.start       = 1'b1;
        bus.numerator   = 16'hFFFF;
        bus.denominator = 16'hF000;
      end
      if (bus.done) begin
        lat       = c;
        q         = bus.quotient;
        z         = bus.dz;
        busy_done = bus.busy;
        break;
      end
    end
    bus.start = 1'b0;
    chk({name, " latency"}, lat, exp_lat, 0);
    chk({name, " quotient"}, q, exp_q, tol);
    chk({name, " dz"}, z, exp_z, 0);
    chk({name, " busy@done"}, busy_done, 1, 0);
    if (inj_cyc > 0) chk({name, " busy@inject"}, busy_inj, 1, 0);
    @(posedge clk); #1;
    chk({name, " done pulse width"}, bus.done, 0, 0);
    chk({name, " busy after"}, bus.busy, 0, 0);
    chk({name, " quotient held"}, bus.quotient, exp_q, tol);
  endtask

  initial begin
    logic seen_done;
    bus.start       = 1'b0;
    bus.numerator   = '0;
    bus.denominator = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", bus.busy, 0, 0);
    chk("rst done", bus.done, 0, 0);
    chk("rst quotient", bus.quotient, 0, 0);
    chk("rst dz", bus.dz, 0, 0);
    reset = 1'b0;

    // Valid divisors: latency 2*4+3 = 11
    run_op("1.5/1.0",    16'hC000, 16'h8000, 16'hC000, 1, 11, 1'b0, 0);
    run_op("1.0/1.5",    16'h8000, 16'hC000, 16'h5555, 1, 11, 1'b0, 0);
    run_op("1.0/1.0",    16'h8000, 16'h8000, 16'h8000, 1, 11, 1'b0, 0);
    run_op("1.0/1.25",   16'h8000, 16'hA000, 16'h6666, 1, 11, 1'b0, 0);
    run_op("1.5/1.25",   16'hC000, 16'hA000, 16'h9999, 1, 11, 1'b0, 0);
    run_op("1.0/1.875",  16'h8000, 16'hF000, 16'h4444, 1, 11, 1'b0, 0);
    run_op("max/1.0",    16'hFFFF, 16'h8000, 16'hFFFF, 1, 11, 1'b0, 0);

    // Invalid divisors: done one cycle after accept, all-ones, dz
    run_op("den 0000",   16'hC000, 16'h0000, 16'hFFFF, 0, 1, 1'b1, 0);
    run_op("den 4000",   16'h8000, 16'h4000, 16'hFFFF, 0, 1, 1'b1, 0);
    run_op("dz cleared", 16'h8000, 16'hC000, 16'h5555, 1, 11, 1'b0, 0);

    // Second request while busy is ignored
    run_op("start ignored", 16'hC000, 16'h8000, 16'hC000, 1, 11, 1'b0, 3);

    // Reset 5 cycles after accept aborts the operation
    @(posedge clk); #1;
    bus.start       = 1'b1;
    bus.numerator   = 16'hC000;
    bus.denominator = 16'h8000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort busy", bus.busy, 0, 0);
    chk("abort quotient", bus.quotient, 0, 0);
    chk("abort done", bus.done, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (bus.done) seen_done = 1'b1;
    end
    chk("abort no done", seen_done, 0, 0);
    chk("abort stays idle", bus.busy, 0, 0);

    run_op("after abort", 16'hE000, 16'hE000, 16'h8000, 1, 11, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
